// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in, serial-out transmitter.
package piso_pkg;

   typedef enum logic {IDLE, SHIFT} piso_state_t;

   localparam int PISO_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/piso_bit_counter.sv
// Bit position counter for the serializer: sync clear, increment enable,
// terminal count at WIDTH-1.
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_WIDTH_DEFAULT,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

   assign tc = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: bit 0 first, one bit per shift_en cycle,
// back-to-back words with no bubble when the next word is waiting.
//
//   state | meaning
//   IDLE  | no word held, ready to accept a new one
//   SHIFT | presenting shreg[0]; advances only when shift_en is high
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH = PISO_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             serial_last,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);

   piso_state_t      state;
   piso_state_t      state_nxt;
   logic [WIDTH-1:0] shreg;
   logic             do_load;
   logic             do_shift;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             cnt_tc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      do_load    = 1'b0;
      do_shift   = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) begin
               do_load   = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (shift_en) begin
               if (cnt_tc) begin
                  load_ready = 1'b1;
                  cnt_clr    = 1'b1;
                  if (load_valid) begin
                     do_load = 1'b1;
                  end else begin
                     // final shift empties shreg so serial_out returns to 0 in IDLE
                     do_shift  = 1'b1;
                     state_nxt = IDLE;
                  end
               end else begin
                  do_shift = 1'b1;
                  cnt_inc  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
      end else if (do_load) begin
         shreg <= load_data;
      end else if (do_shift) begin
         shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
   end

   piso_bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_counter (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .tc  (cnt_tc)
   );

   assign serial_out   = shreg[0];
   assign serial_valid = (state == SHIFT);
   assign busy         = (state == SHIFT);
   assign serial_last  = (state == SHIFT) && cnt_tc;

endmodule
